pwm_duty_measure: RTL and testbench

Receive-side companion to the team's 10-step PWM generator. Samples an asynchronous PWM input and measures its period and high time in clk cycles. Converts the ratio into a duty value in tenths (0..10), matching the generator's DUTY_CYCLE encoding. The value drives the FND/LEDs for loop-back checking or for monitoring an external PWM (e.g. motor driver feedback).

---
 rtl/pwm_duty_measure.sv | 139 +++++++++++++
 tb/tb_pwm_duty_measure.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_measure.sv
// rtl/pwm_duty_measure.sv - PWM period/high-time measurement with duty in tenths
// Synchronizes an async PWM line, times it in clk cycles and divides high*10/period.
module pwm_duty_measure #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pwm_in,
  output logic [3:0]       duty_tenths,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             meas_valid,
  output logic             stuck,
  output logic             overrun
);

  localparam logic [CNT_W-1:0] TO_MAX = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
  state_t state, state_nxt;

  logic             sync1, pwm_s, pwm_d;
  logic             rise, capture, timeout_hit;
  logic             armed;
  logic [CNT_W-1:0] period_cnt, high_cnt;
  logic [CNT_W-1:0] cap_period, cap_high;
  logic [CNT_W+3:0] rem, trial;
  logic [CNT_W-1:0] den;
  logic [3:0]       q;
  logic [1:0]       bit_idx;

  assign rise        = pwm_s & ~pwm_d;
  assign capture     = rise & armed;
  assign timeout_hit = armed & ~rise & (period_cnt == TO_MAX);
  assign trial       = {4'b0, den} << bit_idx;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1 <= 1'b0;
      pwm_s <= 1'b0;
      pwm_d <= 1'b0;
    end else begin
      sync1 <= pwm_in;
      pwm_s <= sync1;
      pwm_d <= pwm_s;
    end
  end

  // A capture arriving mid-division is dropped so the divider operands stay stable.
  always_ff @(posedge clk) begin
    if (!reset) begin
      period_cnt <= '0;
      high_cnt   <= '0;
      armed      <= 1'b0;
      cap_period <= '0;
      cap_high   <= '0;
    end else if (rise) begin
      if (capture && state == IDLE) begin
        cap_period <= period_cnt;
        cap_high   <= high_cnt;
      end
      period_cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
      high_cnt   <= {{(CNT_W-1){1'b0}}, 1'b1};
      armed      <= 1'b1;
    end else begin
      if (period_cnt != TO_MAX) period_cnt <= period_cnt + 1'b1;
      if (pwm_s && high_cnt != TO_MAX) high_cnt <= high_cnt + 1'b1;
      if (timeout_hit) armed <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (capture) state_nxt = DIV;
      DIV:     if (bit_idx == 2'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rem         <= '0;
      den         <= '0;
      q           <= '0;
      bit_idx     <= '0;
      duty_tenths <= '0;
      period_out  <= '0;
      high_out    <= '0;
      meas_valid  <= 1'b0;
      stuck       <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (capture) begin
            rem     <= ({4'b0, high_cnt} << 3) + ({4'b0, high_cnt} << 1);
            den     <= period_cnt;
            q       <= '0;
            bit_idx <= 2'd3;
          end
        end
        DIV: begin
          if (rem >= trial) begin
            rem        <= rem - trial;
            q[bit_idx] <= 1'b1;
          end
          bit_idx <= bit_idx - 2'd1;
        end
        DONE: begin
          duty_tenths <= q;
          period_out  <= cap_period;
          high_out    <= cap_high;
          meas_valid  <= 1'b1;
          stuck       <= 1'b0;
        end
        default: ;
      endcase
      if (capture && state != IDLE) overrun <= 1'b1;
      // Timeout always lands while IDLE because TIMEOUT exceeds the divider latency.
      if (timeout_hit) begin
        stuck       <= 1'b1;
        meas_valid  <= 1'b1;
        period_out  <= '0;
        high_out    <= '0;
        duty_tenths <= pwm_s ? 4'd10 : 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_pwm_duty_measure.sv
// tb/tb_pwm_duty_measure.sv - scoreboard bench for pwm_duty_measure
// Expected measurements come from the pin waveform: rise times and prefix sums of high cycles.
module tb_pwm_duty_measure;

  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 1500;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             pwm_in = 1'b0;
  logic [3:0]       duty_tenths;
  logic [CNT_W-1:0] period_out, high_out;
  logic             meas_valid, stuck, overrun;

  pwm_duty_measure #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .pwm_in(pwm_in), .duty_tenths(duty_tenths),
    .period_out(period_out), .high_out(high_out), .meas_valid(meas_valid),
    .stuck(stuck), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {int period; int high; int duty; bit stk;} exp_t;
  exp_t sbq[$];

  int checks = 0;
  int errors = 0;

  int t = 0, last_rise = 0, ones = 0, ones_at_rise = 0, acc_t = 0;
  bit prev = 0, armed = 0, have_acc = 0, ov_exp = 0;
  bit jitter_mode = 0, mv_prev = 0;
  int jit_count = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
    end
  endtask

  // Reference: one call per clk cycle with the pin level driven in that cycle.
  task automatic model_step(input bit v);
    exp_t e;
    if (v && !prev) begin
      if (armed) begin
        if (have_acc && (t - acc_t) <= 5) ov_exp = 1;
        else begin
          e.period = t - last_rise;
          e.high   = ones - ones_at_rise;
          e.duty   = (e.high * 10) / e.period;
          e.stk    = 0;
          sbq.push_back(e);
          have_acc = 1;
          acc_t    = t;
        end
      end
      armed        = 1;
      last_rise    = t;
      ones_at_rise = ones;
    end else if (armed && (t - last_rise) == TIMEOUT) begin
      e.period = 0;
      e.high   = 0;
      e.duty   = v ? 10 : 0;
      e.stk    = 1;
      sbq.push_back(e);
      armed = 0;
    end
    ones += int'(v);
    prev = v;
    t++;
  endtask

  task automatic step(input bit v);
    @(negedge clk);
    pwm_in = v;
    model_step(v);
  endtask

  task automatic pulse(input int period, input int high);
    for (int i = 0; i < period; i++) step(i < high);
  endtask

  task automatic hold(input int n, input bit v);
    for (int i = 0; i < n; i++) step(v);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_duty"}, int'(duty_tenths), 0);
    check({tag, "_period"}, int'(period_out), 0);
    check({tag, "_high"}, int'(high_out), 0);
    check({tag, "_valid"}, int'(meas_valid), 0);
    check({tag, "_stuck"}, int'(stuck), 0);
    check({tag, "_overrun"}, int'(overrun), 0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset  = 1'b0;
    pwm_in = 1'b0;
    sbq.delete();
    prev = 0; armed = 0; have_acc = 0; ov_exp = 0;
    @(negedge clk);
    check_zero(tag);
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic int jit();
    int d;
    d = int'($urandom_range(0, 8));
    if (d >= 5) d++;
    return d;
  endfunction

  always @(negedge clk) begin
    if (meas_valid) begin
      check("valid_consecutive", int'(mv_prev), 0);
      check_range("duty_range", int'(duty_tenths), 0, 10);
      if (jitter_mode) begin
        jit_count++;
        check_range("jit_period", int'(period_out), 99, 101);
        check_range("jit_high", int'(high_out), 29, 31);
        check_range("jit_duty", int'(duty_tenths), 2, 3);
      end else if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid actual=period %0d high %0d required=no pulse",
                 period_out, high_out);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("period_out", int'(period_out), e.period);
        check("high_out", int'(high_out), e.high);
        check("duty_tenths", int'(duty_tenths), e.duty);
        check("stuck", int'(stuck), int'(e.stk));
      end
    end
    mv_prev = meas_valid;
  end

  initial begin
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b1;

    repeat (8) pulse(10, 5);
    check("overrun_loopback", int'(overrun), 0);

    repeat (3) pulse(10, 1);
    repeat (3) pulse(10, 9);
    repeat (3) pulse(10, 10);
    repeat (3) pulse(10, 1);
    repeat (3) pulse(1000, 333);
    repeat (3) pulse(1000, 999);
    repeat (20) begin
      int p, h;
      p = int'($urandom_range(6, 60));
      h = int'($urandom_range(0, p));
      pulse(p, h);
    end
    check("overrun_sweep", int'(overrun), int'(ov_exp));

    hold(TIMEOUT + 20, 1'b0);
    check("stuck_low", int'(stuck), 1);
    hold(TIMEOUT + 20, 1'b1);
    check("stuck_high", int'(stuck), 1);
    repeat (4) pulse(10, 5);
    hold(10, 1'b0);
    check("stuck_cleared", int'(stuck), 0);

    repeat (12) pulse(4, 2);
    repeat (3) pulse(10, 5);
    hold(10, 1'b0);
    check("overrun_sticky", int'(overrun), 1);
    check("overrun_model", int'(ov_exp), 1);

    repeat (3) pulse(10, 5);
    hold(4, 1'b1);
    do_reset("reset_mid_div");
    repeat (4) pulse(10, 5);
    hold(20, 1'b0);

    do_reset("reset_jitter");
    jitter_mode = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #(jit()) pwm_in = 1'b1;
      repeat (30) @(negedge clk);
      #(jit()) pwm_in = 1'b0;
      repeat (69) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    jitter_mode = 0;
    check("jitter_count", jit_count, 9);
    check("queue_drained", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
